// File: rtl/iir_inverse.sv
// Streaming inverse of the (1+z^-1)/(1-z^-1) IIR: rebuilds x from y with valid/ready and a 2-deep output FIFO.
// Optional IIR_INV_MONITOR_EN adds mon_err_cnt, counting popped samples that differ from a free-running counter.
`timescale 1ns/1ps
module iir_inverse #(
  parameter int W           = 8,
  parameter int PRIME_CHECK = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         resync,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         prime_err,
  output logic [15:0]  sample_cnt
`ifdef IIR_INV_MONITOR_EN
  ,
  output logic [15:0]  mon_err_cnt
`endif
);

  typedef enum logic {PRIME, RUN} state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        s_q, s_d;
  logic [1:0][W-1:0]   buf_q, buf_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                prime_err_q, prime_err_d;
  logic [15:0]         sample_cnt_q, sample_cnt_d;

  logic                accept, push, pop;
  logic [W-1:0]        s_x2, x;

  assign in_ready   = reset & (cnt_q != 2'd2);
  assign out_valid  = (cnt_q != 2'd0);
  assign out_data   = out_valid ? buf_q[rd_ptr_q] : '0;
  assign prime_err  = prime_err_q;
  assign sample_cnt = sample_cnt_q;

  assign accept = in_valid & in_ready;
  assign push   = accept & (state_q == RUN);
  assign pop    = out_valid & out_ready;
  assign s_x2   = s_q << 1;
  assign x      = in_data - s_x2;

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    buf_d        = buf_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    prime_err_d  = prime_err_q;
    sample_cnt_d = sample_cnt_q;
    if (resync) begin
      // resync wins over accept and pop in the same cycle; prime_err survives
      state_d      = PRIME;
      s_d          = '0;
      wr_ptr_d     = 1'b0;
      rd_ptr_d     = 1'b0;
      cnt_d        = 2'd0;
      sample_cnt_d = 16'd0;
    end else begin
      if (accept && state_q == PRIME) begin
        state_d = RUN;
        if (PRIME_CHECK != 0 && in_data != '0) prime_err_d = 1'b1;
      end
      if (push) begin
        buf_d[wr_ptr_q] = x;
        wr_ptr_d        = ~wr_ptr_q;
        s_d             = s_q + x;
      end
      if (pop) begin
        rd_ptr_d     = ~rd_ptr_q;
        sample_cnt_d = sample_cnt_q + 16'd1;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= PRIME;
      s_q          <= '0;
      buf_q        <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      cnt_q        <= 2'd0;
      prime_err_q  <= 1'b0;
      sample_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      buf_q        <= buf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      prime_err_q  <= prime_err_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

`ifdef IIR_INV_MONITOR_EN
  logic [W-1:0] mon_exp_q, mon_exp_d;
  logic [15:0]  mon_err_q, mon_err_d;

  assign mon_err_cnt = mon_err_q;

  always_comb begin
    mon_exp_d = mon_exp_q;
    mon_err_d = mon_err_q;
    if (resync) begin
      mon_exp_d = '0;
    end else if (pop) begin
      mon_exp_d = mon_exp_q + W'(1);
      if (out_data != mon_exp_q && mon_err_q != 16'hFFFF) mon_err_d = mon_err_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mon_exp_q <= '0;
      mon_err_q <= 16'd0;
    end else begin
      mon_exp_q <= mon_exp_d;
      mon_err_q <= mon_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_iir_inverse.sv
// Scoreboard bench for iir_inverse: a forward-IIR model builds y from known x, the DUT output must give x back.
`timescale 1ns/1ps
module tb_iir_inverse;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         resync = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         prime_err;
  logic [15:0]  sample_cnt;
`ifdef IIR_INV_MONITOR_EN
  logic [15:0]  mon_err_cnt;
`endif

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_e;
  logic [W-1:0] fwd_s = '0;

  iir_inverse #(.W(W), .PRIME_CHECK(1)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .resync(resync),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .prime_err(prime_err), .sample_cnt(sample_cnt)
`ifdef IIR_INV_MONITOR_EN
    , .mon_err_cnt(mon_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: a pop happens at the next rising edge whenever this holds at the falling edge.
  always @(negedge clk) begin
    if (reset && !resync && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: out_data=%0h but no sample expected", out_data);
      end else begin
        sb_e = exp_q.pop_front();
        if (out_data !== sb_e) begin
          fails++;
          $display("FAIL sb_data: out_data=%0h expected %0h", out_data, sb_e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_y(input logic [W-1:0] y, input bit do_push, input logic [W-1:0] x);
    int n = 0;
    in_data  = y;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end else if (do_push) begin
      exp_q.push_back(x);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Forward IIR: the y paired with x[n] is x[n] + 2*s[n], then s advances by x[n].
  task automatic feed_x(input logic [W-1:0] x);
    logic [W-1:0] y;
    y = x + (fwd_s << 1);
    send_y(y, 1'b1, x);
    fwd_s = fwd_s + x;
  endtask

  task automatic do_resync();
    resync = 1'b1;
    @(posedge clk); #1;
    resync = 1'b0;
    exp_q.delete();
    fwd_s = '0;
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || out_valid) && n < 100);
    tests++;
    if (exp_q.size() != 0 || out_valid) begin
      fails++;
      $display("FAIL drain: pending=%0d out_valid=%0b required 0 and 0", exp_q.size(), out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({out_valid, out_data, prime_err, sample_cnt, in_ready} !== '0) begin
      fails++;
      $display("FAIL reset_state: valid=%0b data=%0h perr=%0b cnt=%0d rdy=%0b required all 0",
               out_valid, out_data, prime_err, sample_cnt, in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_y(8'd0, 1'b0, 8'd0);
    send_y(8'd0, 1'b1, 8'd0);
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'd0) begin
      fails++;
      $display("FAIL latency: valid=%0b data=%0h required 1 and 0", out_valid, out_data);
    end
    send_y(8'd1,  1'b1, 8'd1);
    send_y(8'd4,  1'b1, 8'd2);
    send_y(8'd9,  1'b1, 8'd3);
    send_y(8'd16, 1'b1, 8'd4);
    wait_drain();
    tests++;
    if (sample_cnt !== 16'd5 || prime_err !== 1'b0) begin
      fails++;
      $display("FAIL basic_cnt: sample_cnt=%0d prime_err=%0b required 5 and 0", sample_cnt, prime_err);
    end
  endtask

  task automatic test_midstream();
    do_resync();
    tests++;
    if (sample_cnt !== 16'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL resync_clear: sample_cnt=%0d valid=%0b required 0 and 0", sample_cnt, out_valid);
    end
    out_ready = 1'b1;
    send_y(8'd0, 1'b0, 8'd0);
    send_y(8'h40, 1'b1, 8'h40);
    send_y(8'h80, 1'b1, 8'h00);
    tests++;
    if (out_data !== 8'h00) begin
      fails++;
      $display("FAIL midstream_x: out_data=%0h required 00", out_data);
    end
    // s must still be 0x40, so 0x90 decodes to 0x10
    send_y(8'h90, 1'b1, 8'h10);
    wait_drain();
    tests++;
    if (sample_cnt !== 16'd3) begin
      fails++;
      $display("FAIL midstream_cnt: sample_cnt=%0d required 3", sample_cnt);
    end
  endtask

  task automatic test_prime_err();
    do_resync();
    out_ready = 1'b1;
    send_y(8'h05, 1'b0, 8'd0);
    repeat (3) @(negedge clk);
    tests++;
    if (prime_err !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL prime_err_set: prime_err=%0b out_valid=%0b required 1 and 0", prime_err, out_valid);
    end
    @(posedge clk); #1;
    do_resync();
    tests++;
    if (prime_err !== 1'b1 || sample_cnt !== 16'd0) begin
      fails++;
      $display("FAIL prime_err_sticky: prime_err=%0b sample_cnt=%0d required 1 and 0", prime_err, sample_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] y3;
    do_resync();
    out_ready = 1'b0;
    send_y(8'd0, 1'b0, 8'd0);
    feed_x(8'd3);
    feed_x(8'd9);
    y3 = 8'd20 + (fwd_s << 1);
    in_data  = y3;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'd3) begin
      fails++;
      $display("FAIL backpressure: rdy=%0b valid=%0b data=%0h required 0 1 03", in_ready, out_valid, out_data);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    feed_x(8'd20);
    feed_x(8'd200);
    wait_drain();
    tests++;
    if (sample_cnt !== 16'd4) begin
      fails++;
      $display("FAIL backpressure_cnt: sample_cnt=%0d required 4", sample_cnt);
    end
  endtask

  task automatic test_reset_midburst();
    do_resync();
    out_ready = 1'b0;
    send_y(8'd0, 1'b0, 8'd0);
    feed_x(8'h11);
    feed_x(8'h22);
    reset = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || sample_cnt !== 16'd0 || prime_err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: valid=%0b rdy=%0b cnt=%0d perr=%0b required 0 0 0 0",
               out_valid, in_ready, sample_cnt, prime_err);
    end
    exp_q.delete();
    fwd_s = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    send_y(8'h33, 1'b0, 8'd0);
    feed_x(8'd0);
    feed_x(8'd1);
    feed_x(8'd2);
    wait_drain();
    tests++;
    if (prime_err !== 1'b1 || sample_cnt !== 16'd3) begin
      fails++;
      $display("FAIL reprime: prime_err=%0b sample_cnt=%0d required 1 and 3", prime_err, sample_cnt);
    end
  endtask

  task automatic test_sawtooth();
    do_resync();
    out_ready = 1'b1;
    send_y(8'd0, 1'b0, 8'd0);
    for (int i = 0; i < 600; i++) feed_x(W'(i));
    wait_drain();
    tests++;
    if (sample_cnt !== 16'd600) begin
      fails++;
      $display("FAIL sawtooth_cnt: sample_cnt=%0d required 600", sample_cnt);
    end
`ifdef IIR_INV_MONITOR_EN
    tests++;
    if (mon_err_cnt !== 16'd0) begin
      fails++;
      $display("FAIL mon_err_cnt: mon_err_cnt=%0d required 0", mon_err_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midstream();
    test_prime_err();
    test_back_to_back();
    test_reset_midburst();
    test_sawtooth();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
